// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
//   slave  : the queue itself (accepts IF pushes, presents head to ID)
//   master : the environment driving IF_* / ID_enable and observing status
interface inst_queue_if #(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned ADDR_BUS_WIDTH = 32
);
  logic                      IF_valid;
  logic [INST_WIDTH-1:0]     IF_inst;
  logic [ADDR_BUS_WIDTH-1:0] IF_pc;
  logic                      IF_queue_is_full;
  logic                      ID_enable;
  logic                      ID_queue_is_empty;
  logic [INST_WIDTH-1:0]     ID_inst;
  logic [ADDR_BUS_WIDTH-1:0] ID_pc;

  modport slave (
    input  IF_valid, IF_inst, IF_pc, ID_enable,
    output IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc
  );

  modport master (
    output IF_valid, IF_inst, IF_pc, ID_enable,
    input  IF_queue_is_full, ID_queue_is_empty, ID_inst, ID_pc
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction FIFO between fetch (IF) and decode (ID).
// Buffers {inst, pc} in program order, presents the head first-word-fall-through,
// and is flushed by ROB_clear on a branch mispredict.
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   rdy        global ready; low freezes all state
//   ROB_clear  flush request; empties the queue (same-cycle push/pop discarded)
//   q          inst_queue_if.slave: IF push side and ID head/pop side
module inst_queue #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned ADDR_BUS_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         ROB_clear,
  inst_queue_if.slave  q
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [INST_WIDTH-1:0]     inst;
    logic [ADDR_BUS_WIDTH-1:0] pc;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [CNT_W-1:0]      count;

  logic push_c;
  logic pop_c;
  logic full_c;
  logic empty_c;

  // Full/empty come from the registered count only, so ID_enable never
  // reaches the IF side combinationally.
  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == CNT_W'(0));
  assign push_c  = q.IF_valid  & ~full_c;
  assign pop_c   = q.ID_enable & ~empty_c;

  // Storage: written only on an accepted push; zeroed on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (rdy && !ROB_clear && push_c) begin
      mem[tail] <= '{inst: q.IF_inst, pc: q.IF_pc};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at ADDR_WIDTH bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (ROB_clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_c) tail <= tail + ADDR_WIDTH'(1);
        if (pop_c)  head <= head + ADDR_WIDTH'(1);
        case ({push_c, pop_c})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign q.IF_queue_is_full  = full_c;
  assign q.ID_queue_is_empty = empty_c;
  assign q.ID_inst           = mem[head].inst;
  assign q.ID_pc             = mem[head].pc;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;
  logic rdy;
  logic ROB_clear;

  inst_queue_if #(.INST_WIDTH(32), .ADDR_BUS_WIDTH(32)) bus ();

  inst_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(4), .INST_WIDTH(32), .ADDR_BUS_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .ROB_clear (ROB_clear),
    .q         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the queue contents in program order, {inst, pc} per entry.
  logic [63:0] model_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("empty", 64'(bus.ID_queue_is_empty), 64'(model_q.size() == 0));
    check("full",  64'(bus.IF_queue_is_full),  64'(model_q.size() == int'(DEPTH)));
    if (model_q.size() != 0) begin
      check("head_inst", 64'(bus.ID_inst), 64'(model_q[0][63:32]));
      check("head_pc",   64'(bus.ID_pc),   64'(model_q[0][31:0]));
    end
  endtask

  // One clock: check state left by the previous edge, drive, then apply the
  // queue rules to the model at the edge.
  task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ide, input logic clr, input logic r);
    int sz;
    @(negedge clk);
    check_outputs();
    bus.IF_valid  = iv;
    bus.IF_inst   = inst;
    bus.IF_pc     = pc;
    bus.ID_enable = ide;
    ROB_clear     = clr;
    rdy           = r;
    @(posedge clk);
    if (r) begin
      if (clr) begin
        model_q.delete();
      end else begin
        sz = model_q.size();
        if (ide && sz > 0) void'(model_q.pop_front());
        if (iv && sz < int'(DEPTH)) model_q.push_back({inst, pc});
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [31:0] next_pc;

  initial begin
    rst = 1'b0; rdy = 1'b1; ROB_clear = 1'b0;
    bus.IF_valid = 1'b0; bus.IF_inst = '0; bus.IF_pc = '0; bus.ID_enable = 1'b0;
    #12;
    // Reset values, before any clock edge releases reset.
    check("rst_empty", 64'(bus.ID_queue_is_empty), 64'd1);
    check("rst_full",  64'(bus.IF_queue_is_full),  64'd0);
    check("rst_inst",  64'(bus.ID_inst), 64'd0);
    check("rst_pc",    64'(bus.ID_pc),   64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Pop while empty is ignored.
    idle();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();

    // Single push, visible next cycle, then popped.
    step(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();

    // Fill to 16, drop a 17th, push+pop while full pops only, then drain.
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hDEAD_BEEF, 32'd64, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hCAFE_F00D, 32'd68, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();

    // Fill to 10, then sustained push+pop across pointer wrap, then drain.
    next_pc = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, next_pc, 1'b0, 1'b0, 1'b1);
      next_pc += 4;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, $urandom, next_pc, 1'b1, 1'b0, 1'b1);
      next_pc += 4;
    end
    for (int i = 0; i < 11; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Flush at count=5 with a same-cycle push and pop; fresh push follows.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 32'(32'h2000 + i * 4), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1111_1111, 32'h2100, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h2222_2222, 32'h3000, 1'b0, 1'b0, 1'b1);
    idle();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Hold with rdy low at count=3 while inputs toggle.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'(32'h4000 + i * 4), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'(i), $urandom, 32'h5000, 1'(~i), 1'(i >> 1), 1'b0);
    idle();

    // Asynchronous reset mid-cycle, no clock edge required.
    bus.IF_valid = 1'b0; bus.ID_enable = 1'b0; ROB_clear = 1'b0; rdy = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_empty", 64'(bus.ID_queue_is_empty), 64'd1);
    check("async_full",  64'(bus.IF_queue_is_full),  64'd0);
    check("async_inst",  64'(bus.ID_inst), 64'd0);
    check("async_pc",    64'(bus.ID_pc),   64'd0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic: biased toward pushes early so the queue reaches full.
    for (int i = 0; i < 600; i++) begin
      logic iv, ide, clr, r;
      iv  = ($urandom_range(99) < ((i % 200) < 100 ? 80 : 40));
      ide = ($urandom_range(99) < ((i % 200) < 100 ? 30 : 70));
      clr = ($urandom_range(99) < 2);
      r   = ($urandom_range(99) < 90);
      step(iv, $urandom, $urandom, ide, clr, r);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
